// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync-header encodings and block-lock states.
package pcs_pkg;

    localparam int unsigned HEADER_WIDTH = 2;
    localparam logic [HEADER_WIDTH-1:0] SH_DATA = 2'b01;
    localparam logic [HEADER_WIDTH-1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        RESET_CNT,
        TEST_SH,
        SLIP_WAIT
    } lock_state_t;

    // Only 01 and 10 are legal sync headers; 00 and 11 mean misalignment.
    function automatic logic sh_is_valid(input logic [HEADER_WIDTH-1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b receive block synchroniser (Clause 49 style lock state machine).
// Tests sync headers in windows of SH_CNT_MAX, requests bit slips on bad
// alignment and reports block lock. All outputs are registered.
// Optional build macro RX_BLOCK_LOCK_STATS_EN adds saturating slip and
// lock-loss counters as extra output ports.
module rx_block_lock
    import pcs_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX     = 64,
    parameter int unsigned SH_INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT      = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [HEADER_WIDTH-1:0] i_header,
    input  logic                    i_header_valid,
    output logic                    o_slip,
    output logic                    o_block_lock
`ifdef RX_BLOCK_LOCK_STATS_EN
    ,
    output logic [15:0]             o_slip_count,
    output logic [15:0]             o_lock_loss_count
`endif
);

    localparam int unsigned CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
    localparam logic [CNT_W-1:0]  INV_LAST  = CNT_W'(SH_INVALID_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    // State literals are package-scoped because the SLIP_WAIT parameter
    // shadows the enumerator of the same name.
    lock_state_t       state_q, state_d;
    logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [CNT_W-1:0]  sh_invalid_cnt_q, sh_invalid_cnt_d;
    logic [WAIT_W-1:0] slip_wait_cnt_q, slip_wait_cnt_d;
    logic              slip_q, slip_d;
    logic              block_lock_q, block_lock_d;

    logic              hdr_ok;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  inv_base;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  inv_inc;
    logic              window_done;
    logic              lock_lost;

    // Header classification and window arithmetic for the header on this cycle.
    always_comb begin
        hdr_ok = sh_is_valid(i_header);
        // RESET_CNT opens a fresh window, so its header counts from zero.
        if (state_q == pcs_pkg::RESET_CNT) begin
            cnt_base = '0;
            inv_base = '0;
        end else begin
            cnt_base = sh_cnt_q;
            inv_base = sh_invalid_cnt_q;
        end
        cnt_inc     = cnt_base + CNT_W'(1);
        inv_inc     = hdr_ok ? inv_base : inv_base + CNT_W'(1);
        window_done = (cnt_inc == CNT_LAST);
        lock_lost   = block_lock_q && !hdr_ok && (inv_inc == INV_LAST);
    end

    // Next-state logic for the lock state machine and its registered outputs.
    always_comb begin
        state_d          = state_q;
        sh_cnt_d         = sh_cnt_q;
        sh_invalid_cnt_d = sh_invalid_cnt_q;
        slip_wait_cnt_d  = slip_wait_cnt_q;
        slip_d           = 1'b0;
        block_lock_d     = block_lock_q;

        unique case (state_q)
            pcs_pkg::RESET_CNT, pcs_pkg::TEST_SH: begin
                if (state_q == pcs_pkg::RESET_CNT) begin
                    state_d          = pcs_pkg::TEST_SH;
                    sh_cnt_d         = '0;
                    sh_invalid_cnt_d = '0;
                end
                if (i_header_valid) begin
                    sh_cnt_d         = cnt_inc;
                    sh_invalid_cnt_d = inv_inc;
                    if ((!block_lock_q && !hdr_ok) || lock_lost) begin
                        // Misaligned: request one slip and let it settle.
                        slip_d           = 1'b1;
                        block_lock_d     = 1'b0;
                        sh_cnt_d         = '0;
                        sh_invalid_cnt_d = '0;
                        slip_wait_cnt_d  = '0;
                        state_d          = pcs_pkg::SLIP_WAIT;
                    end else if (window_done) begin
                        // A clean unlocked window acquires lock; a locked one holds it.
                        block_lock_d = 1'b1;
                        state_d      = pcs_pkg::RESET_CNT;
                    end
                end
            end
            pcs_pkg::SLIP_WAIT: begin
                // The slip pulse cycle is the first of the SLIP_WAIT ignored cycles.
                if (slip_wait_cnt_q == WAIT_LAST) begin
                    slip_wait_cnt_d = '0;
                    state_d         = pcs_pkg::RESET_CNT;
                end else begin
                    slip_wait_cnt_d = slip_wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = pcs_pkg::RESET_CNT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q          <= pcs_pkg::RESET_CNT;
            sh_cnt_q         <= '0;
            sh_invalid_cnt_q <= '0;
            slip_wait_cnt_q  <= '0;
            slip_q           <= 1'b0;
            block_lock_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            sh_cnt_q         <= sh_cnt_d;
            sh_invalid_cnt_q <= sh_invalid_cnt_d;
            slip_wait_cnt_q  <= slip_wait_cnt_d;
            slip_q           <= slip_d;
            block_lock_q     <= block_lock_d;
        end
    end

    assign o_slip       = slip_q;
    assign o_block_lock = block_lock_q;

`ifdef RX_BLOCK_LOCK_STATS_EN
    logic [15:0] slip_count_q, slip_count_d;
    logic [15:0] lock_loss_count_q, lock_loss_count_d;

    // Saturating event counters, updated on the same edge as the outputs change.
    always_comb begin
        slip_count_d      = slip_count_q;
        lock_loss_count_d = lock_loss_count_q;
        if (slip_d && (slip_count_q != 16'hFFFF)) begin
            slip_count_d = slip_count_q + 16'd1;
        end
        if (block_lock_q && !block_lock_d && (lock_loss_count_q != 16'hFFFF)) begin
            lock_loss_count_d = lock_loss_count_q + 16'd1;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            slip_count_q      <= '0;
            lock_loss_count_q <= '0;
        end else begin
            slip_count_q      <= slip_count_d;
            lock_loss_count_q <= lock_loss_count_d;
        end
    end

    assign o_slip_count      = slip_count_q;
    assign o_lock_loss_count = lock_loss_count_q;
`endif

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: a table of stimulus phases with
// end-of-phase expectations, plus a per-cycle reference model feeding a
// scoreboard queue. Honours RX_BLOCK_LOCK_STATS_EN when defined.
module tb_rx_block_lock;

    localparam int unsigned SH_CNT_MAX     = 64;
    localparam int unsigned SH_INVALID_MAX = 16;
    localparam int unsigned SLIP_WAIT      = 32;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [1:0] i_header = 2'b00;
    logic       i_header_valid = 1'b0;
    logic       o_slip;
    logic       o_block_lock;
`ifdef RX_BLOCK_LOCK_STATS_EN
    logic [15:0] o_slip_count;
    logic [15:0] o_lock_loss_count;
`endif

    rx_block_lock #(
        .SH_CNT_MAX     (SH_CNT_MAX),
        .SH_INVALID_MAX (SH_INVALID_MAX),
        .SLIP_WAIT      (SLIP_WAIT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_header       (i_header),
        .i_header_valid (i_header_valid),
        .o_slip         (o_slip),
        .o_block_lock   (o_block_lock)
`ifdef RX_BLOCK_LOCK_STATS_EN
        ,
        .o_slip_count      (o_slip_count),
        .o_lock_loss_count (o_lock_loss_count)
`endif
    );

    always #5 clk = ~clk;

    // Phase modes: 0 constant inputs, 1 valid on even cycles (00 otherwise),
    // 2 always valid with n_bad 2'b11 headers on every other slot counted from the end.
    typedef struct {
        string      name;
        int         n;
        bit         rst;
        bit         v;
        logic [1:0] hdr;
        int         mode;
        int         n_bad;
        bit         exp_lock;
        int         exp_slips;
    } phase_t;

    typedef struct packed {
        logic slip;
        logic lock;
    } exp_t;

    phase_t ph[$];
    exp_t   sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int phase_slips = 0;

    // Reference model state
    bit m_lock, m_slip;
    int m_cnt, m_bad, m_wait, m_slips, m_losses;

    task automatic add(input string name, input int n, input bit rst, input bit v,
                       input logic [1:0] hdr, input int mode, input int n_bad,
                       input bit exp_lock, input int exp_slips);
        phase_t p;
        p.name = name; p.n = n; p.rst = rst; p.v = v; p.hdr = hdr; p.mode = mode;
        p.n_bad = n_bad; p.exp_lock = exp_lock; p.exp_slips = exp_slips;
        ph.push_back(p);
    endtask

    task automatic model_step(input bit r, input bit v, input logic [1:0] h);
        bit good;
        if (r) begin
            m_lock = 0; m_slip = 0; m_cnt = 0; m_bad = 0; m_wait = 0;
            m_slips = 0; m_losses = 0;
            return;
        end
        m_slip = 0;
        if (m_wait > 0) begin
            m_wait--;
        end else if (v) begin
            good = (h == 2'b01) || (h == 2'b10);
            m_cnt++;
            if (!good) m_bad++;
            if (!good && (!m_lock || m_bad == SH_INVALID_MAX)) begin
                if (m_lock) m_losses++;
                m_lock = 0; m_slip = 1; m_slips++;
                m_cnt = 0; m_bad = 0; m_wait = SLIP_WAIT;
            end else if (m_cnt == SH_CNT_MAX) begin
                m_lock = 1; m_cnt = 0; m_bad = 0;
            end
        end
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        n_checks++;
        if (o_slip !== e.slip) begin
            n_fail++;
            $display("FAIL slip @%0t: got %b expected %b", $time, o_slip, e.slip);
        end
        n_checks++;
        if (o_block_lock !== e.lock) begin
            n_fail++;
            $display("FAIL block_lock @%0t: got %b expected %b", $time, o_block_lock, e.lock);
        end
        if (o_slip === 1'b1) phase_slips++;
    endtask

    task automatic check_phase(input int p);
        n_checks++;
        if (o_block_lock !== ph[p].exp_lock) begin
            n_fail++;
            $display("FAIL phase %s lock: got %b expected %b", ph[p].name, o_block_lock,
                     ph[p].exp_lock);
        end
        n_checks++;
        if (phase_slips != ph[p].exp_slips) begin
            n_fail++;
            $display("FAIL phase %s slips: got %0d expected %0d", ph[p].name, phase_slips,
                     ph[p].exp_slips);
        end
`ifdef RX_BLOCK_LOCK_STATS_EN
        n_checks++;
        if (o_slip_count !== 16'(m_slips)) begin
            n_fail++;
            $display("FAIL phase %s slip_count: got %0d expected %0d", ph[p].name,
                     o_slip_count, m_slips);
        end
        n_checks++;
        if (o_lock_loss_count !== 16'(m_losses)) begin
            n_fail++;
            $display("FAIL phase %s lock_loss_count: got %0d expected %0d", ph[p].name,
                     o_lock_loss_count, m_losses);
        end
`endif
        phase_slips = 0;
    endtask

    // One cycle: compare what the previous edge produced, then drive the next inputs.
    task automatic tick(input bit r, input bit v, input logic [1:0] h, input int chk);
        exp_t e;
        @(negedge clk);
        check_sb();
        if (chk >= 0) check_phase(chk);
        i_reset = r;
        i_header_valid = v;
        i_header = h;
        model_step(r, v, h);
        e.slip = m_slip;
        e.lock = m_lock;
        sb.push_back(e);
    endtask

    initial begin
        bit v;
        logic [1:0] h;
        int k;
        //  name           n    rst v  hdr    mode bad lock slips
        add("reset0",       2,   1, 0, 2'b00, 0,   0,  0,   0);
        add("lock64",       64,  0, 1, 2'b01, 0,   0,  1,   0);
        add("reset1",       1,   1, 0, 2'b00, 0,   0,  0,   0);
        add("ctrl9",        9,   0, 1, 2'b10, 0,   0,  0,   0);
        add("bad00",        1,   0, 1, 2'b00, 0,   0,  0,   1);
        add("wait32",       32,  0, 1, 2'b11, 0,   0,  0,   0);
        add("after_wait",   1,   0, 1, 2'b11, 0,   0,  0,   1);
        add("idle40a",      40,  0, 0, 2'b00, 0,   0,  0,   0);
        add("relock63",     63,  0, 1, 2'b01, 0,   0,  0,   0);
        add("relock64",     1,   0, 1, 2'b10, 0,   0,  1,   0);
        add("win15a",       64,  0, 1, 2'b10, 2,   15, 1,   0);
        add("win15b",       64,  0, 1, 2'b01, 2,   15, 1,   0);
        add("loss40",       40,  0, 1, 2'b01, 2,   16, 0,   1);
        add("idle40b",      40,  0, 0, 2'b00, 0,   0,  0,   0);
        add("toggle",       128, 0, 1, 2'b01, 1,   0,  1,   0);
        add("reset2",       1,   1, 0, 2'b00, 0,   0,  0,   0);
        add("bad00b",       1,   0, 1, 2'b00, 0,   0,  0,   1);
        add("midwait",      10,  0, 0, 2'b00, 0,   0,  0,   0);
        add("rst_wait",     1,   1, 0, 2'b00, 0,   0,  0,   0);
        add("after_rst63",  63,  0, 1, 2'b01, 0,   0,  0,   0);
        add("after_rst64",  1,   0, 1, 2'b01, 0,   0,  1,   0);

        model_step(1'b1, 1'b0, 2'b00);

        for (int p = 0; p < ph.size(); p++) begin
            for (int i = 0; i < ph[p].n; i++) begin
                case (ph[p].mode)
                    1: begin
                        v = (i % 2 == 0);
                        h = v ? ph[p].hdr : 2'b00;
                    end
                    2: begin
                        k = ph[p].n - 1 - i;
                        v = 1'b1;
                        h = ((k % 2 == 0) && (k / 2 < ph[p].n_bad)) ? 2'b11 : ph[p].hdr;
                    end
                    default: begin
                        v = ph[p].v;
                        h = ph[p].hdr;
                    end
                endcase
                tick(ph[p].rst, v, h, (i == 0 && p > 0) ? p - 1 : -1);
            end
        end
        tick(1'b0, 1'b0, 2'b00, ph.size() - 1);
        @(negedge clk);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
